int_div_unit: RTL

- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits in the integer execute stage and is the responder to the hazard unit's divide board.
- Accepts a start pulse (IDiv) with operands, runs multi-cycle, and returns the result with a one-cycle Div_Done pulse.
- Div_Done releases the hazard unit's divide stall.

---
 rtl/int_div_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/int_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases (divide by zero, signed overflow) finish in one cycle.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            IDiv,
  input  logic [1:0]      Div_Op,
  input  logic [XLEN-1:0] Dividend,
  input  logic [XLEN-1:0] Divisor,
  input  logic            Div_Kill,
  output logic [XLEN-1:0] Div_Result,
  output logic            Div_Done,
  output logic            Div_Busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic rem_sel;
    logic quot_neg;
    logic rem_neg;
  } div_ctl_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  div_ctl_t        ctl;
  logic [XLEN-1:0] rem_q, quot_q, dvs_q;
  logic [CNT_W-1:0] cnt;
  logic            done_q;

  logic            is_signed, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign is_signed   = ~Div_Op[0];
  assign abs_a       = (is_signed && Dividend[XLEN-1]) ? -Dividend : Dividend;
  assign abs_b       = (is_signed && Divisor[XLEN-1])  ? -Divisor  : Divisor;
  assign div_zero    = (Divisor == '0);
  assign ovf         = is_signed && (Dividend == INT_MIN) && (Divisor == '1);
  assign special_res = div_zero ? (Div_Op[1] ? Dividend : '1)
                                : (Div_Op[1] ? '0 : INT_MIN);

  // Trial subtraction is one bit wider than the operands; its MSB is the borrow.
  logic [XLEN:0]   rem_sh, trial;
  logic            take;
  logic [XLEN-1:0] rem_nx, quot_nx, q_fix, r_fix;

  assign rem_sh  = {rem_q, quot_q[XLEN-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign take    = ~trial[XLEN];
  assign rem_nx  = take ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nx = {quot_q[XLEN-2:0], take};
  assign q_fix   = ctl.quot_neg ? -quot_nx : quot_nx;
  assign r_fix   = ctl.rem_neg  ? -rem_nx  : rem_nx;

  // A flush suppresses a completion pulse landing in the same cycle.
  assign Div_Done = done_q & ~Div_Kill;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      ctl        <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      cnt        <= '0;
      done_q     <= 1'b0;
      Div_Busy   <= 1'b0;
      Div_Result <= '0;
    end else if (Div_Kill) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      Div_Busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (IDiv) begin
            ctl.rem_sel  <= Div_Op[1];
            ctl.quot_neg <= is_signed & (Dividend[XLEN-1] ^ Divisor[XLEN-1]);
            ctl.rem_neg  <= is_signed & Dividend[XLEN-1];
            Div_Busy     <= 1'b1;
            if (div_zero || ovf) begin
              Div_Result <= special_res;
              done_q     <= 1'b1;
              state      <= DONE;
            end else begin
              rem_q  <= '0;
              quot_q <= abs_a;
              dvs_q  <= abs_b;
              cnt    <= CNT_W'(XLEN-1);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_nx;
          quot_q <= quot_nx;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            Div_Result <= ctl.rem_sel ? r_fix : q_fix;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done_q   <= 1'b0;
          Div_Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
